// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester and consumer handshake bundle for the 4:1 round-robin mux arbiter.
interface mux4_rr_arbiter_if #(parameter int WIDTH = 32);
  logic [3:0]       req;
  logic [3:0]       ack;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic             s0;
  logic             s1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  modport master (output req, din0, din1, din2, din3, out_ready,
                  input  ack, s0, s1, out_valid, out_data);
  modport slave  (input  req, din0, din1, din2, din3, out_ready,
                  output ack, s0, s1, out_valid, out_data);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin pick among four requesters into a single-entry registered output stage.
module mux4_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  mux4_rr_arbiter_if.slave bus
);
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;
  logic             state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       win, idx;
  logic             load;
  logic [WIDTH-1:0] din_sel;
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    // descending scan so the nearest requester above ptr wins last
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (bus.req[idx]) win = idx;
    end
    load    = (state_q == EMPTY || bus.out_ready) && |bus.req && !rst;
    din_sel = win == 2'd0 ? bus.din0 : win == 2'd1 ? bus.din1 : win == 2'd2 ? bus.din2 : bus.din3;
    data_d  = load ? din_sel : data_q;
    sel_d   = load ? win : sel_q;
    ptr_d   = load ? win + 2'd1 : ptr_q;
    state_d = load ? FULL : (state_q == FULL && bus.out_ready) ? EMPTY : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end
  assign bus.ack       = load ? 4'b0001 << win : 4'b0000;
  assign bus.out_valid = state_q == FULL;
  assign bus.out_data  = data_q;
  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: vector table, directed corner sequences and a randomized run against a queue-free reference model.
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  mux4_rr_arbiter_if #(.WIDTH(32)) bus ();
  mux4_rr_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  ack;
    logic        valid;
    logic [31:0] data;
    logic [1:0]  sel;
  } vec_t;
  vec_t vecs[18];
  int mptr;
  bit mvalid;
  logic [31:0] mdata;
  int msel;
  logic [31:0] din[4];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask
  task automatic drive_din();
    bus.din0 = din[0];
    bus.din1 = din[1];
    bus.din2 = din[2];
    bus.din3 = din[3];
  endtask
  task automatic step(input string n, input logic [3:0] r, input logic rdy, input logic [3:0] eack,
                      input logic ev, input logic [31:0] ed, input logic [1:0] es);
    bus.req = r;
    bus.out_ready = rdy;
    #1 chk({n, ".ack"}, 64'(bus.ack), 64'(eack));
    @(posedge clk);
    #1;
    chk({n, ".valid"}, 64'(bus.out_valid), 64'(ev));
    chk({n, ".data"}, 64'(bus.out_data), 64'(ed));
    chk({n, ".sel"}, 64'({bus.s1, bus.s0}), 64'(es));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    vecs = '{
      '{4'b0001, 1'b1, 4'b0001, 1'b1, 32'd1, 2'd0},
      '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'd2, 2'd1},
      '{4'b1111, 1'b1, 4'b0100, 1'b1, 32'd3, 2'd2},
      '{4'b1111, 1'b1, 4'b1000, 1'b1, 32'd4, 2'd3},
      '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'd1, 2'd0},
      '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'd2, 2'd1},
      '{4'b1111, 1'b1, 4'b0100, 1'b1, 32'd3, 2'd2},
      '{4'b1111, 1'b1, 4'b1000, 1'b1, 32'd4, 2'd3},
      '{4'b1010, 1'b1, 4'b0010, 1'b1, 32'd2, 2'd1},
      '{4'b1010, 1'b1, 4'b1000, 1'b1, 32'd4, 2'd3},
      '{4'b1010, 1'b1, 4'b0010, 1'b1, 32'd2, 2'd1},
      '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'd2, 2'd1},
      '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'd2, 2'd1},
      '{4'b0100, 1'b0, 4'b0100, 1'b1, 32'd3, 2'd2},
      '{4'b0100, 1'b0, 4'b0000, 1'b1, 32'd3, 2'd2},
      '{4'b0100, 1'b0, 4'b0000, 1'b1, 32'd3, 2'd2},
      '{4'b0100, 1'b1, 4'b0100, 1'b1, 32'd3, 2'd2},
      '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'd3, 2'd2}
    };
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    din = '{32'hA5A5_0001, 32'd2, 32'd3, 32'd4};
    drive_din();
    @(posedge clk);
    #1;
    chk("rst.ack", 64'(bus.ack), 64'd0);
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.data", 64'(bus.out_data), 64'd0);
    chk("rst.sel", 64'({bus.s1, bus.s0}), 64'd0);
    do_reset();
    step("first", 4'b0001, 1'b1, 4'b0001, 1'b1, 32'hA5A5_0001, 2'd0);
    do_reset();
    din = '{32'd1, 32'd2, 32'd3, 32'd4};
    drive_din();
    for (int i = 0; i < 18; i++)
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].rdy, vecs[i].ack, vecs[i].valid, vecs[i].data, vecs[i].sel);
    // ptr is 3 here; granting requester 1 leaves ptr at 2 with the stage full
    step("preptr2", 4'b0010, 1'b1, 4'b0010, 1'b1, 32'd2, 2'd1);
    bus.req = 4'b1111;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", 64'(bus.out_valid), 64'd0);
    chk("arst.data", 64'(bus.out_data), 64'd0);
    chk("arst.sel", 64'({bus.s1, bus.s0}), 64'd0);
    chk("arst.ack", 64'(bus.ack), 64'd0);
    #1 rst = 1'b0;
    step("arst.after", 4'b1111, 1'b1, 4'b0001, 1'b1, 32'd1, 2'd0);
    do_reset();
    mptr = 0;
    mvalid = 1'b0;
    mdata = '0;
    msel = 0;
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r, eack, pend;
      logic rdy;
      int win;
      pend = bus.req & ~bus.ack;
      for (int i = 0; i < 4; i++) if (!pend[i]) din[i] = $urandom;
      drive_din();
      r = 4'($urandom_range(0, 15));
      rdy = $urandom_range(0, 3) != 0;
      bus.req = r;
      bus.out_ready = rdy;
      win = -1;
      if ((!mvalid || rdy) && r != 0)
        for (int k = 3; k >= 0; k--) if (r[(mptr + k) % 4]) win = (mptr + k) % 4;
      eack = win >= 0 ? 4'(1 << win) : 4'd0;
      #1 chk("rnd.ack", 64'(bus.ack), 64'(eack));
      @(posedge clk);
      #1;
      if (win >= 0) begin
        mdata = din[win];
        msel = win;
        mvalid = 1'b1;
        mptr = (win + 1) % 4;
      end else if (mvalid && rdy) mvalid = 1'b0;
      chk("rnd.valid", 64'(bus.out_valid), 64'(mvalid));
      chk("rnd.data", 64'(bus.out_data), 64'(mdata));
      chk("rnd.sel", 64'({bus.s1, bus.s0}), 64'(msel));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
